// File: rtl/barcodescanner_nios_altmemddr_0_ex_lfsr_checker_if.sv
// Bus bundle for the LFSR read-data checker: run control, read beats and run statistics.
interface barcodescanner_nios_altmemddr_0_ex_lfsr_checker_if #(
    parameter int unsigned LANES = 4
);
    logic               start;
    logic               rdata_valid;
    logic [8*LANES-1:0] rdata;
    logic               busy;
    logic               done;
    logic               pass;
    logic [15:0]        err_count;
    logic [LANES-1:0]   lane_fail;
    logic [15:0]        first_err_beat;

    modport master (
        output start, rdata_valid, rdata,
        input  busy, done, pass, err_count, lane_fail, first_err_beat
    );

    modport slave (
        input  start, rdata_valid, rdata,
        output busy, done, pass, err_count, lane_fail, first_err_beat
    );
endinterface

// File: rtl/barcodescanner_nios_altmemddr_0_ex_lfsr_checker.sv
// Per-lane 8-bit LFSR checker for memory read data; runs NUM_BEATS beats per start pulse.
// Optional first-mismatch beat capture is built only when LFSR_CHECKER_FIRST_ERR_EN is defined.
module barcodescanner_nios_altmemddr_0_ex_lfsr_checker #(
    parameter int unsigned SEED      = 32,
    parameter int unsigned LANES     = 4,
    parameter int unsigned NUM_BEATS = 256
) (
    input logic clk,
    input logic reset_n,
    barcodescanner_nios_altmemddr_0_ex_lfsr_checker_if.slave bus
);

    localparam logic [1:0]  IDLE      = 2'd0;
    localparam logic [1:0]  CHECK     = 2'd1;
    localparam logic [1:0]  DONE      = 2'd2;
    localparam int unsigned W         = 8 * LANES;
    localparam logic [15:0] LAST_BEAT = 16'(NUM_BEATS);

    function automatic logic [W-1:0] seed_vec();
        logic [W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            v[8*i +: 8] = 8'((SEED + i) % 256);
        end
        return v;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] d);
        return {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     lfsr_q, lfsr_d;
    logic [15:0]      beat_cnt_q, beat_cnt_d;
    logic [15:0]      err_count_q, err_count_d;
    logic [LANES-1:0] lane_fail_q, lane_fail_d;
    logic             pass_q, pass_d;
    logic [LANES-1:0] lane_mis;
    logic             beat;
    logic             run_start;

    always_comb begin
        lane_mis = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_mis[i] = bus.rdata[8*i +: 8] != lfsr_q[8*i +: 8];
        end
    end

    assign beat      = (state_q == CHECK) && bus.rdata_valid;
    assign run_start = (state_q == IDLE) && bus.start;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        beat_cnt_d  = beat_cnt_q;
        err_count_d = err_count_q;
        lane_fail_d = lane_fail_q;
        pass_d      = pass_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    lfsr_d      = seed_vec();
                    beat_cnt_d  = '0;
                    err_count_d = '0;
                    lane_fail_d = '0;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (bus.rdata_valid) begin
                    for (int unsigned i = 0; i < LANES; i++) begin
                        lfsr_d[8*i +: 8] = lfsr_step(lfsr_q[8*i +: 8]);
                    end
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    // One count per failing beat, regardless of how many lanes failed.
                    if (|lane_mis) begin
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                        lane_fail_d = lane_fail_q | lane_mis;
                    end
                    if (beat_cnt_d == LAST_BEAT) begin
                        state_d = DONE;
                        pass_d  = (err_count_d == 16'd0);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lfsr_q      <= seed_vec();
            beat_cnt_q  <= '0;
            err_count_q <= '0;
            lane_fail_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            beat_cnt_q  <= beat_cnt_d;
            err_count_q <= err_count_d;
            lane_fail_q <= lane_fail_d;
            pass_q      <= pass_d;
        end
    end

`ifdef LFSR_CHECKER_FIRST_ERR_EN
    logic [15:0] first_err_q, first_err_d;

    // err_count is still zero only on the first failing beat of a run.
    always_comb begin
        first_err_d = first_err_q;
        if (run_start) begin
            first_err_d = '0;
        end else if (beat && (|lane_mis) && (err_count_q == 16'd0)) begin
            first_err_d = beat_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_err_q <= '0;
        end else begin
            first_err_q <= first_err_d;
        end
    end

    assign bus.first_err_beat = first_err_q;
`else
    assign bus.first_err_beat = 16'd0;
`endif

    assign bus.busy      = (state_q == CHECK);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.err_count = err_count_q;
    assign bus.lane_fail = lane_fail_q;

endmodule

// File: tb/tb_barcodescanner_nios_altmemddr_0_ex_lfsr_checker.sv
// Directed bench: a 1-lane/4-beat checker and a 4-lane/256-beat checker on one clock.
module tb_barcodescanner_nios_altmemddr_0_ex_lfsr_checker;

`ifdef LFSR_CHECKER_FIRST_ERR_EN
    localparam bit FirstErrEn = 1'b1;
`else
    localparam bit FirstErrEn = 1'b0;
`endif

    logic clk;
    logic rst_a_n;
    logic rst_b_n;
    int   checks;
    int   errors;
    int   done_cnt_b;
    int   base;
    logic [7:0] m [4];

    barcodescanner_nios_altmemddr_0_ex_lfsr_checker_if #(.LANES(1)) a_if ();
    barcodescanner_nios_altmemddr_0_ex_lfsr_checker_if #(.LANES(4)) b_if ();

    barcodescanner_nios_altmemddr_0_ex_lfsr_checker #(
        .SEED(32), .LANES(1), .NUM_BEATS(4)
    ) u_a (
        .clk(clk), .reset_n(rst_a_n), .bus(a_if.slave)
    );

    barcodescanner_nios_altmemddr_0_ex_lfsr_checker #(
        .SEED(32), .LANES(4), .NUM_BEATS(256)
    ) u_b (
        .clk(clk), .reset_n(rst_b_n), .bus(b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (b_if.done) done_cnt_b++;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference step written as shift-left with conditional feedback of 0x1D.
    function automatic logic [7:0] nxt(input logic [7:0] d);
        return {d[6:0], 1'b0} ^ (d[7] ? 8'h1D : 8'h00);
    endfunction

    task automatic a_beat(input logic [7:0] d);
        a_if.rdata_valid = 1'b1;
        a_if.rdata       = d;
        tick();
        a_if.rdata_valid = 1'b0;
    endtask

    task automatic a_start();
        tick();
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
    endtask

    // Drives n valid beats with an idle (garbage) cycle between them; returns right
    // after the last beat's edge. Lanes in mask are inverted on beat index bad.
    task automatic b_run(input int n, input int bad, input logic [3:0] mask);
        for (int i = 0; i < 4; i++) m[i] = 8'h20 + 8'(i);
        tick();
        b_if.start = 1'b1;
        tick();
        b_if.start = 1'b0;
        for (int k = 0; k < n; k++) begin
            b_if.rdata_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                b_if.rdata[8*i +: 8] = m[i] ^ ((k == bad && mask[i]) ? 8'hFF : 8'h00);
            end
            tick();
            b_if.rdata_valid = 1'b0;
            b_if.rdata       = $urandom;
            for (int i = 0; i < 4; i++) m[i] = nxt(m[i]);
            if (k != n - 1) tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        done_cnt_b = 0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        a_if.start = 1'b0; a_if.rdata_valid = 1'b0; a_if.rdata = '0;
        b_if.start = 1'b0; b_if.rdata_valid = 1'b0; b_if.rdata = '0;
        #1;
        check("rst_busy", 32'(a_if.busy), 32'd0);
        check("rst_done", 32'(a_if.done), 32'd0);
        check("rst_pass", 32'(a_if.pass), 32'd0);
        check("rst_err", 32'(a_if.err_count), 32'd0);
        check("rst_lane_fail", 32'(b_if.lane_fail), 32'd0);
        check("rst_first_err", 32'(a_if.first_err_beat), 32'd0);
        tick();
        tick();
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // Run 1: valid in IDLE, start mid-run and valid in DONE must all be ignored.
        a_if.rdata_valid = 1'b1;
        a_if.rdata       = 8'h55;
        tick();
        tick();
        a_if.rdata_valid = 1'b0;
        a_start();
        check("a1_busy", 32'(a_if.busy), 32'd1);
        a_beat(8'h20);
        a_beat(8'h40);
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        a_beat(8'h80);
        a_beat(8'h1D);
        a_if.rdata_valid = 1'b1;
        a_if.rdata       = 8'h00;
        check("a1_done", 32'(a_if.done), 32'd1);
        check("a1_pass", 32'(a_if.pass), 32'd1);
        check("a1_err", 32'(a_if.err_count), 32'd0);
        check("a1_lane_fail", 32'(a_if.lane_fail), 32'd0);
        tick();
        a_if.rdata_valid = 1'b0;
        check("a1_done_low", 32'(a_if.done), 32'd0);
        check("a1_idle", 32'(a_if.busy), 32'd0);
        check("a1_err_after_done", 32'(a_if.err_count), 32'd0);

        // Run 2: third beat corrupted.
        a_start();
        check("a2_pass_held", 32'(a_if.pass), 32'd1);
        a_beat(8'h20);
        a_beat(8'h40);
        a_beat(8'h81);
        a_beat(8'h1D);
        check("a2_done", 32'(a_if.done), 32'd1);
        check("a2_pass", 32'(a_if.pass), 32'd0);
        check("a2_err", 32'(a_if.err_count), 32'd1);
        check("a2_lane_fail", 32'(a_if.lane_fail), 32'd1);
        check("a2_first_err", 32'(a_if.first_err_beat), FirstErrEn ? 32'd2 : 32'd0);
        tick();
        check("a2_err_hold", 32'(a_if.err_count), 32'd1);
        check("a2_lane_fail_hold", 32'(a_if.lane_fail), 32'd1);

        // Run 3: a new start clears the statistics, then passes.
        a_start();
        check("a3_err_clr", 32'(a_if.err_count), 32'd0);
        check("a3_lane_fail_clr", 32'(a_if.lane_fail), 32'd0);
        a_beat(8'h20);
        a_beat(8'h40);
        a_beat(8'h80);
        a_beat(8'h1D);
        check("a3_pass", 32'(a_if.pass), 32'd1);

        // Wide checker: lanes 0 and 3 corrupted on beat 100.
        base = done_cnt_b;
        b_run(256, 100, 4'b1001);
        check("b1_done", 32'(b_if.done), 32'd1);
        check("b1_pass", 32'(b_if.pass), 32'd0);
        check("b1_err", 32'(b_if.err_count), 32'd1);
        check("b1_lane_fail", 32'(b_if.lane_fail), 32'h9);
        check("b1_first_err", 32'(b_if.first_err_beat), FirstErrEn ? 32'd100 : 32'd0);
        tick();
        tick();
        check("b1_done_pulses", 32'(done_cnt_b - base), 32'd1);

        // Clean run with valid toggling every other cycle.
        b_run(255, -1, 4'b0000);
        tick();
        check("b2_not_done_255", 32'(b_if.done), 32'd0);
        check("b2_busy_255", 32'(b_if.busy), 32'd1);
        b_if.rdata_valid = 1'b1;
        for (int i = 0; i < 4; i++) b_if.rdata[8*i +: 8] = m[i];
        tick();
        b_if.rdata_valid = 1'b0;
        check("b2_done", 32'(b_if.done), 32'd1);
        check("b2_pass", 32'(b_if.pass), 32'd1);
        check("b2_err", 32'(b_if.err_count), 32'd0);
        check("b2_lane_fail", 32'(b_if.lane_fail), 32'd0);

        // Abort with reset after 10 beats, one of them bad.
        tick();
        base = done_cnt_b;
        b_run(10, 5, 4'b1001);
        check("b3_err_pre", 32'(b_if.err_count), 32'd1);
        #2;
        rst_b_n = 1'b0;
        #1;
        check("b3_busy", 32'(b_if.busy), 32'd0);
        check("b3_done", 32'(b_if.done), 32'd0);
        check("b3_pass", 32'(b_if.pass), 32'd0);
        check("b3_err", 32'(b_if.err_count), 32'd0);
        check("b3_lane_fail", 32'(b_if.lane_fail), 32'd0);
        check("b3_first_err", 32'(b_if.first_err_beat), 32'd0);
        tick();
        tick();
        rst_b_n = 1'b1;
        repeat (5) tick();
        check("b3_no_restart", 32'(b_if.busy), 32'd0);
        check("b3_no_done", 32'(done_cnt_b - base), 32'd0);

        b_run(256, -1, 4'b0000);
        check("b4_done", 32'(b_if.done), 32'd1);
        check("b4_pass", 32'(b_if.pass), 32'd1);
        check("b4_err", 32'(b_if.err_count), 32'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/barcodescanner_nios_altmemddr_0_ex_lfsr_checker.md
BARCODESCANNER_NIOS_ALTMEMDDR_0_EX_LFSR_CHECKER -- requirements
Module: barcodescanner_nios_altmemddr_0_ex_lfsr_checker

Interface
REQ-001 SHALL have parameter SEED, default 32: base seed; lane i seeds with (SEED+i) mod 256.
REQ-002 SHALL have parameter LANES, default 4: number of 8-bit byte lanes checked per beat.
REQ-003 SHALL have parameter NUM_BEATS, default 256: beats per check run; legal range 1..65535.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a run.
REQ-007 SHALL have port rdata_valid  in  1  rdata holds a read beat this cycle.
REQ-008 SHALL have port rdata  in  8*LANES  read data; lane i at bits [8i+7:8i].
REQ-009 SHALL have port busy  out  1  high while a run is in progress.
REQ-010 SHALL have port done  out  1  one-cycle pulse at the end of a run.
REQ-011 SHALL have port pass  out  1  result of the last completed run.
REQ-012 SHALL have port err_count  out  16  count of mismatching beats, saturating.
REQ-013 SHALL have port lane_fail  out  LANES  sticky per-lane mismatch flags.
REQ-014 SHALL have port first_err_beat  out  16  beat index of the first mismatch.

Function
REQ-015 SHALL keep one 8-bit LFSR per lane that steps as: n0=d7; n1=d0; n2=d1^d7; n3=d2^d7; n4=d3^d7; n5=d4; n6=d5; n7=d6.
REQ-016 SHALL implement states IDLE, CHECK and DONE.
REQ-017 IDLE: busy=0; start=1 -> load all lane LFSRs with their seeds, clear beat_cnt, err_count, lane_fail and first_err_beat, hold pass, go to CHECK.
REQ-018 CHECK: busy=1; on each rdata_valid=1 cycle, compare every rdata lane with its LFSR value, step all LFSRs once and increment beat_cnt.
REQ-019 CHECK: cycles with rdata_valid=0 SHALL not step the LFSRs or change beat_cnt.
REQ-020 A beat with one or more mismatching lanes SHALL add exactly 1 to err_count, which holds at 0xFFFF once saturated.
REQ-021 A mismatch SHALL set lane_fail bits for the failing lanes; on the first mismatching beat of a run, first_err_beat SHALL capture beat_cnt.
REQ-022 On the beat that makes beat_cnt equal NUM_BEATS, the block SHALL go to DONE; the statistics SHALL include that beat.
REQ-023 DONE: done=1 for exactly one cycle; pass=1 only if err_count==0 including the final beat; go to IDLE next cycle.
REQ-024 start SHALL be ignored in CHECK and DONE; rdata_valid SHALL be ignored in IDLE and DONE.
REQ-025 err_count, lane_fail and first_err_beat SHALL hold their values after DONE until the next accepted start.

Reset
REQ-026 When reset_n=0, the block SHALL asynchronously enter IDLE with busy=0, done=0, pass=0, err_count=0, lane_fail=0, first_err_beat=0, beat_cnt=0 and every LFSR at its seed.
REQ-027 Reset asserted during CHECK SHALL abort the run with no done pulse; the first run after release starts only on a new start pulse.

Configuration
REQ-028 With macro LFSR_CHECKER_FIRST_ERR_EN defined, first_err_beat SHALL behave as in REQ-021.
REQ-029 Without LFSR_CHECKER_FIRST_ERR_EN, first_err_beat SHALL be constant 0 and no capture register SHALL be built; all other behaviour is unchanged.

Verification
REQ-030 LANES=1, SEED=32, NUM_BEATS=4: drive beats 0x20,0x40,0x80,0x1D -> one done pulse, pass=1, err_count=0, lane_fail=0.
REQ-031 Same setup, third beat driven as 0x81 -> pass=0, err_count=1, lane_fail=1, first_err_beat=2 (0 without the macro).
REQ-032 LANES=4, NUM_BEATS=256, rdata_valid toggling every other cycle, correct data -> done occurs after the 256th valid beat and pass=1.
REQ-033 Lanes 0 and 3 corrupted on one beat -> err_count=1 and lane_fail=4'b1001.
REQ-034 Drive reset_n=0 after 10 valid beats -> all outputs return to reset values immediately with no done pulse; a new run then passes.
REQ-035 Assert start during CHECK and drive rdata_valid in IDLE -> neither affects the run or the statistics.
